icache_fetch: RTL
=================

ICACHE_FETCH -- requirements
Module: icache_fetch

Interface
- REQ-001 SHALL have parameter NSETS, default 8, number of direct-mapped lines (power of two).
- REQ-002 SHALL have parameter LINEWORDS, default 4, 32-bit words per line (fixed at 4 for this revision).
- REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
- REQ-005 SHALL have port pcF, input, 32, fetch-stage PC from the pipeline.
- REQ-006 SHALL have port instrF, output, 32, instruction word delivered to the fetch/decode register.
- REQ-007 SHALL have port istall, output, 1, high while the requested instruction is not available; the pipeline ORs it into its fetch and decode stalls.
- REQ-008 SHALL have port inval, input, 1, synchronous invalidate-all request.
- REQ-009 SHALL have port mem_req, output, 1, refill read request to main memory.
- REQ-010 SHALL have port mem_addr, output, 32, word address of the refill read.
- REQ-011 SHALL have port mem_ack, input, 1, memory returns mem_rdata for the current mem_addr this cycle.
- REQ-012 SHALL have port mem_rdata, input, 32, refill data.

Function
- REQ-013 SHALL decode pcF as offset = pcF[3:2], index = pcF[6:4], tag = pcF[31:7] at NSETS=8; pcF[1:0] ignored.
- REQ-014 SHALL store per line: valid bit, 25-bit tag, 4 x 32-bit data words.
- REQ-015 SHALL define hit = state IDLE and valid[index] and stored tag == tag, all combinational from pcF.
- REQ-016 SHALL, on hit, drive instrF = data[index][offset] and istall = 0 in the same cycle (zero-latency hit).
- REQ-017 SHALL, when not hit, drive istall = 1 and instrF = 32'h0000_0000 (NOP).
- REQ-018 SHALL implement FSM states IDLE and FILL only.
- REQ-019 SHALL, in IDLE on a miss with inval = 0, latch line address pcF[31:4], clear word counter, and enter FILL next cycle.
- REQ-020 SHALL, in FILL, hold mem_req = 1 and mem_addr = {latched line, counter, 2'b00}; both remain stable until mem_ack.
- REQ-021 SHALL, on each FILL cycle with mem_ack = 1, write mem_rdata into word [counter] of the latched line and increment the counter (2 bits).
- REQ-022 SHALL, on the ack with counter = 3, set valid and tag of the latched line, drop mem_req the next cycle, and return to IDLE; the re-presented pcF hits one cycle later.
- REQ-023 SHALL fill the latched line even if pcF changes during FILL; the new pcF is evaluated only once back in IDLE.
- REQ-024 SHALL keep mem_req = 0 in IDLE; mem_ack while IDLE is ignored.
- REQ-025 SHALL, on inval = 1, clear all valid bits at the next edge; in IDLE it also suppresses miss detection that cycle.
- REQ-026 SHALL, on inval during FILL, clear all valid bits, finish the current refill, and leave the refilled line invalid when inval coincides with the final ack (inval wins).
- REQ-027 SHALL replace any valid line at the same index on refill (no replacement policy beyond direct-mapped).

Reset
- REQ-028 SHALL, while reset = 0, asynchronously force state IDLE, counter 0, all valid bits 0, mem_req 0, mem_addr 0.
- REQ-029 SHALL, on reset asserted mid-FILL, abandon the refill; the partially written line stays invalid; data/tag arrays need no reset.
- REQ-030 SHALL drive istall = 1 and instrF = 0 immediately after reset release for any pcF (all lines invalid).

Verification
- REQ-031 Cold miss: pcF=0x0000_0040, memory acks every cycle with 0xA0..0xA3 -> mem_addr 0x40,0x44,0x48,0x4C; istall high 5 cycles; then instrF=0xA0, istall=0.
- REQ-032 Hit sweep: after REQ-031 fill, pcF=0x44/0x48/0x4C -> instrF 0xA1/0xA2/0xA3 same cycle, mem_req stays 0.
- REQ-033 Conflict: pcF=0x0000_00C0 (same index 4, new tag) -> refill replaces line; pcF=0x40 then misses again.
- REQ-034 Slow memory: mem_ack pulsed every 3rd cycle -> mem_addr/mem_req held stable between acks; 4 words landed in order.
- REQ-035 Invalidate: inval=1 coincident with final ack -> line not valid; same pcF misses and refills.
- REQ-036 Reset mid-FILL: reset=0 after 2 acks -> mem_req=0 asynchronously; after release pcF=0x40 misses and refills from word 0.

Source files
------------

// File: rtl/icache_fetch_if.sv
// Fetch-side bundle of the instruction cache: pipeline PC/instruction path plus the refill read port.
// The cache uses the slave view; the pipeline and memory together use the master view.
interface icache_fetch_if;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        istall;
  logic        inval;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  pcF, inval, mem_ack, mem_rdata,
    output instrF, istall, mem_req, mem_addr
  );

  modport master (
    output pcF, inval, mem_ack, mem_rdata,
    input  instrF, istall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with zero-latency hits and a blocking one-word-per-ack line refill.
// state  | meaning
// S_IDLE | serving hits, detecting misses;  S_FILL | refilling the latched line, one word per mem_ack
module icache_fetch #(
  parameter int NSETS     = 8,
  parameter int LINEWORDS = 4
) (
  input logic           clk,
  input logic           reset,
  icache_fetch_if.slave bus
);
  localparam int OW = $clog2(LINEWORDS);
  localparam int IW = $clog2(NSETS);
  localparam int LW = 30 - OW;
  localparam int TW = LW - IW;
  localparam logic [0:0]    S_IDLE    = 1'b0;
  localparam logic [0:0]    S_FILL    = 1'b1;
  localparam logic [OW-1:0] LAST_WORD = OW'(LINEWORDS - 1);

  logic [0:0]       state_q, state_d;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    line_q, line_d;
  logic [NSETS-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [NSETS];
  logic [31:0]      data_q [NSETS][LINEWORDS];

  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic          hit;
  logic          fill_ack;
  logic          fill_last;
  logic          unused_pc_lsb;

  assign pc_off        = bus.pcF[OW+1:2];
  assign pc_idx        = bus.pcF[OW+IW+1:OW+2];
  assign pc_tag        = bus.pcF[31:OW+IW+2];
  assign unused_pc_lsb = ^bus.pcF[1:0];
  assign fill_idx      = line_q[IW-1:0];
  assign fill_tag      = line_q[LW-1:IW];
  assign fill_ack      = (state_q == S_FILL) && bus.mem_ack;
  assign fill_last     = fill_ack && (cnt_q == LAST_WORD);

  assign hit          = (state_q == S_IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign bus.instrF   = hit ? data_q[pc_idx][pc_off] : 32'h0000_0000;
  assign bus.istall   = ~hit;
  assign bus.mem_req  = (state_q == S_FILL);
  assign bus.mem_addr = (state_q == S_FILL) ? {line_q, cnt_q, 2'b00} : 32'h0000_0000;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.inval && !hit) begin
          // the old occupant is dropped up front so a half-written line can never look valid
          line_d          = bus.pcF[31:OW+2];
          cnt_d           = '0;
          valid_d[pc_idx] = 1'b0;
          state_d         = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (fill_last) begin
            valid_d[fill_idx] = 1'b1;
            state_d           = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.inval) valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_ack) begin
      data_q[fill_idx][cnt_q] <= bus.mem_rdata;
      if (fill_last) tag_q[fill_idx] <= fill_tag;
    end
  end
endmodule
